// File: rtl/lab3_cache_mem_responder_pkg.sv
// Shared memory-message types for the cache's downstream 4B request/response
// interface, plus the responder's FSM state encoding.
package lab3_cache_mem_responder_pkg;

  localparam logic [2:0] MEM_READ  = 3'd0;
  localparam logic [2:0] MEM_WRITE = 3'd1;
  localparam logic [2:0] MEM_INIT  = 3'd2;

  localparam logic [1:0] TEST_OK  = 2'b00;
  localparam logic [1:0] TEST_ERR = 2'b01;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/lab3_cache_mem_responder_array.sv
// Word-addressed backing store: byte-enabled synchronous write, registered read.
// Contents are deliberately not reset so they survive a responder reset.
module lab3_cache_mem_responder_array #(
  parameter int NUM_WORDS = 256,
  localparam int IDX_W = $clog2(NUM_WORDS)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] idx,
  input  logic             wen,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  input  logic             ren,
  output logic [31:0]      rdata
);

  logic [31:0] mem [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (wen) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (ren) rdata <= mem[idx];
  end

endmodule

// File: rtl/lab3_cache_mem_responder.sv
// Fixed-latency memory responder: accepts one request at a time, commits writes
// and samples reads at acceptance, and returns the response after LATENCY cycles.
module lab3_cache_mem_responder
  import lab3_cache_mem_responder_pkg::*;
#(
  parameter int NUM_WORDS = 256,
  parameter int LATENCY   = 2,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memreq_val,
  output logic             memreq_rdy,
  input  mem_req_4B_t      memreq_msg,
  output logic             memresp_val,
  input  logic             memresp_rdy,
  output mem_resp_4B_t     memresp_msg,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  function automatic logic [2:0] req_nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 3'd4 : {1'b0, len};
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] nb, input logic [1:0] off);
    logic [3:0] m;
    case (nb)
      3'd1:    m = 4'b0001;
      3'd2:    m = 4'b0011;
      3'd3:    m = 4'b0111;
      default: m = 4'b1111;
    endcase
    return m << off;
  endfunction

  function automatic logic [31:0] fmt_read(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] nb);
    logic [31:0] s;
    logic [31:0] m;
    s = w >> {off, 3'b000};
    case (nb)
      3'd1:    m = 32'h0000_00FF;
      3'd2:    m = 32'h0000_FFFF;
      3'd3:    m = 32'h00FF_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return s & m;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic       accept, req_err, is_rd, is_wr, known;
  logic [1:0] off;
  logic [2:0] nbytes;
  logic       arr_wen, arr_ren;
  logic [31:0] arr_rdata;

  // Request decode (combinational on the presented message)
  assign off     = memreq_msg.addr[1:0];
  assign nbytes  = req_nbytes(memreq_msg.len);
  assign is_rd   = (memreq_msg.type_ == MEM_READ);
  assign is_wr   = (memreq_msg.type_ == MEM_WRITE) || (memreq_msg.type_ == MEM_INIT);
  assign known   = is_rd || is_wr;
  assign req_err = (memreq_msg.addr[31:2] >= 30'(NUM_WORDS))
                || (({2'b00, off} + {1'b0, nbytes}) > 4'd4)
                || !known;

  // Gating with reset keeps the array from being written while held in reset.
  assign memreq_rdy  = (state_q == ST_IDLE) && reset;
  assign memresp_val = (state_q == ST_RESP);
  assign busy        = (state_q != ST_IDLE);
  assign accept      = memreq_val && memreq_rdy;
  assign arr_wen     = accept && is_wr && !req_err;
  assign arr_ren     = accept && is_rd && !req_err;

  lab3_cache_mem_responder_array #(
    .NUM_WORDS(NUM_WORDS)
  ) u_array (
    .clk   (clk),
    .idx   (memreq_msg.addr[IDX_W+1:2]),
    .wen   (arr_wen),
    .be    (byte_en(nbytes, off)),
    .wdata (memreq_msg.data << {off, 3'b000}),
    .ren   (arr_ren),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = ST_RESP;
          end else begin
            cnt_d   = LAT_M1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        if (memresp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response stage: header and read-format controls captured at acceptance
  logic [2:0] type_p1;
  logic [7:0] opaque_p1;
  logic [1:0] test_p1, len_p1, off_p1;
  logic [2:0] nb_p1;
  logic       rd_ok_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      type_p1   <= '0;
      opaque_p1 <= '0;
      test_p1   <= '0;
      len_p1    <= '0;
      off_p1    <= '0;
      nb_p1     <= '0;
      rd_ok_p1  <= 1'b0;
      err_count <= '0;
    end else if (accept) begin
      type_p1   <= memreq_msg.type_;
      opaque_p1 <= memreq_msg.opaque;
      test_p1   <= req_err ? TEST_ERR : TEST_OK;
      len_p1    <= memreq_msg.len;
      off_p1    <= off;
      nb_p1     <= nbytes;
      rd_ok_p1  <= is_rd && !req_err;
      if (req_err && (err_count != {ERR_W{1'b1}})) err_count <= err_count + 1'b1;
    end
  end

  // Array read data is not reset, so rd_ok_p1 forces zero data after reset.
  always_comb begin
    memresp_msg        = '0;
    memresp_msg.type_  = type_p1;
    memresp_msg.opaque = opaque_p1;
    memresp_msg.test   = test_p1;
    memresp_msg.len    = len_p1;
    memresp_msg.data   = rd_ok_p1 ? fmt_read(arr_rdata, off_p1, nb_p1) : 32'h0;
  end

endmodule

// File: tb/tb_lab3_cache_mem_responder.sv
// Scoreboard bench for the memory responder: a LATENCY=2 instance for the main
// scenarios and a LATENCY=0, ERR_W=2 instance for back-to-back and saturation.
module tb_lab3_cache_mem_responder;
  import lab3_cache_mem_responder_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // LATENCY=2 instance
  logic         memreq_val = 1'b0, memreq_rdy, memresp_val, memresp_rdy = 1'b1, busy;
  mem_req_4B_t  memreq_msg = '0;
  mem_resp_4B_t memresp_msg;
  logic [7:0]   err_count;

  lab3_cache_mem_responder #(.NUM_WORDS(256), .LATENCY(2), .ERR_W(8)) dut (
    .clk(clk), .reset(reset),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
    .busy(busy), .err_count(err_count)
  );

  // LATENCY=0 instance
  logic         memreq_val0 = 1'b0, memreq_rdy0, memresp_val0, memresp_rdy0 = 1'b1, busy0;
  mem_req_4B_t  memreq_msg0 = '0;
  mem_resp_4B_t memresp_msg0;
  logic [1:0]   err_count0;

  lab3_cache_mem_responder #(.NUM_WORDS(256), .LATENCY(0), .ERR_W(2)) dut0 (
    .clk(clk), .reset(reset),
    .memreq_val(memreq_val0), .memreq_rdy(memreq_rdy0), .memreq_msg(memreq_msg0),
    .memresp_val(memresp_val0), .memresp_rdy(memresp_rdy0), .memresp_msg(memresp_msg0),
    .busy(busy0), .err_count(err_count0)
  );

  mem_resp_4B_t expq[$];
  mem_resp_4B_t expq0[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic mem_req_4B_t mk_req(input logic [2:0] t, input logic [7:0] op,
                                         input logic [31:0] a, input logic [1:0] l,
                                         input logic [31:0] d);
    mem_req_4B_t r;
    r.type_ = t; r.opaque = op; r.addr = a; r.len = l; r.data = d;
    return r;
  endfunction

  function automatic mem_resp_4B_t mk_resp(input logic [2:0] t, input logic [7:0] op,
                                           input logic [1:0] ts, input logic [1:0] l,
                                           input logic [31:0] d);
    mem_resp_4B_t r;
    r.type_ = t; r.opaque = op; r.test = ts; r.len = l; r.data = d;
    return r;
  endfunction

  // Monitors: compare on every response handshake
  always @(negedge clk) begin
    if (reset && memresp_val && memresp_rdy) begin
      if (expq.size() == 0) chk("unexpected_resp", 64'(memresp_msg), 64'h0);
      else chk($sformatf("resp_op%0h", expq[0].opaque), 64'(memresp_msg), 64'(expq.pop_front()));
    end
    if (reset && memresp_val0 && memresp_rdy0) begin
      if (expq0.size() == 0) chk("unexpected_resp0", 64'(memresp_msg0), 64'h0);
      else chk($sformatf("resp0_op%0h", expq0[0].opaque), 64'(memresp_msg0), 64'(expq0.pop_front()));
    end
  end

  // Presents a request from posedge+1 and returns at posedge+1 of its accept edge.
  task automatic send(input mem_req_4B_t req, input mem_resp_4B_t exp);
    int n;
    n = 0;
    expq.push_back(exp);
    memreq_msg = req;
    memreq_val = 1'b1;
    @(negedge clk);
    while (!memreq_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!memreq_rdy) chk("send_timeout", 64'(n), 64'h0);
    @(posedge clk);
    #1 memreq_val = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || busy) && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    if (n >= 100) chk("drain_timeout", 64'(expq.size()), 64'h0);
  endtask

  task automatic wait_val(output int n);
    n = 0;
    while (!memresp_val && n < 30) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_req_4B_t  req;
    mem_resp_4B_t held;
    mem_req_4B_t  reqs0[7];
    mem_resp_4B_t exps0[7];
    int acc0[7];
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_val", 64'(memresp_val), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_err", 64'(err_count), 64'h0);
    chk("rst_msg", 64'(memresp_msg), 64'h0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 chk("rst_rdy", 64'(memreq_rdy), 64'h1);

    // INIT then READ with latency measurement
    send(mk_req(MEM_INIT, 8'h01, 32'h10, 2'd0, 32'hDEADBEEF), mk_resp(MEM_INIT, 8'h01, TEST_OK, 2'd0, 32'h0));
    drain();
    send(mk_req(MEM_READ, 8'h02, 32'h10, 2'd0, 32'h0), mk_resp(MEM_READ, 8'h02, TEST_OK, 2'd0, 32'hDEADBEEF));
    wait_val(n);
    chk("latency_edges", 64'(n), 64'd2);
    drain();

    // Sub-word write and reads
    send(mk_req(MEM_WRITE, 8'h03, 32'h11, 2'd1, 32'h000000AA), mk_resp(MEM_WRITE, 8'h03, TEST_OK, 2'd1, 32'h0));
    send(mk_req(MEM_READ, 8'h04, 32'h10, 2'd0, 32'h0), mk_resp(MEM_READ, 8'h04, TEST_OK, 2'd0, 32'hDEADAAEF));
    send(mk_req(MEM_READ, 8'h05, 32'h12, 2'd2, 32'h0), mk_resp(MEM_READ, 8'h05, TEST_OK, 2'd2, 32'h0000DEAD));
    drain();

    // Back-pressure: response held, pending request must not be taken
    memresp_rdy = 1'b0;
    send(mk_req(MEM_READ, 8'h06, 32'h11, 2'd1, 32'h0), mk_resp(MEM_READ, 8'h06, TEST_OK, 2'd1, 32'h000000AA));
    wait_val(n);
    held = memresp_msg;
    req = mk_req(MEM_READ, 8'h10, 32'h10, 2'd0, 32'h0);
    memreq_msg = req;
    memreq_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_val", 64'(memresp_val), 64'h1);
      chk("stall_msg", 64'(memresp_msg), 64'(held));
      chk("stall_reqrdy", 64'(memreq_rdy), 64'h0);
    end
    @(posedge clk);
    #1 memresp_rdy = 1'b1;
    @(posedge clk);
    #1 chk("post_hs_reqrdy", 64'(memreq_rdy), 64'h1);
    send(req, mk_resp(MEM_READ, 8'h10, TEST_OK, 2'd0, 32'hDEADAAEF));
    drain();

    // Errors: out of range, word-crossing write, unknown type
    send(mk_req(MEM_READ, 8'h07, 32'h400, 2'd0, 32'h0), mk_resp(MEM_READ, 8'h07, TEST_ERR, 2'd0, 32'h0));
    send(mk_req(MEM_WRITE, 8'h08, 32'h13, 2'd2, 32'h1234), mk_resp(MEM_WRITE, 8'h08, TEST_ERR, 2'd2, 32'h0));
    drain();
    chk("err_count_2", 64'(err_count), 64'd2);
    send(mk_req(MEM_READ, 8'h09, 32'h10, 2'd0, 32'h0), mk_resp(MEM_READ, 8'h09, TEST_OK, 2'd0, 32'hDEADAAEF));
    send(mk_req(MEM_WRITE, 8'h0A, 32'h3FC, 2'd0, 32'hCAFEF00D), mk_resp(MEM_WRITE, 8'h0A, TEST_OK, 2'd0, 32'h0));
    send(mk_req(MEM_READ, 8'h0B, 32'h3FF, 2'd1, 32'h0), mk_resp(MEM_READ, 8'h0B, TEST_OK, 2'd1, 32'h000000CA));
    send(mk_req(3'd3, 8'h0C, 32'h10, 2'd0, 32'h0), mk_resp(3'd3, 8'h0C, TEST_ERR, 2'd0, 32'h0));
    drain();
    chk("err_count_3", 64'(err_count), 64'd3);

    // Reset during WAIT drops the response but keeps array contents
    send(mk_req(MEM_READ, 8'h0D, 32'h10, 2'd0, 32'h0), mk_resp(MEM_READ, 8'h0D, TEST_OK, 2'd0, 32'hDEADAAEF));
    chk("inflight_busy", 64'(busy), 64'h1);
    reset = 1'b0;
    #1;
    void'(expq.pop_back());
    chk("mid_rst_val", 64'(memresp_val), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    chk("mid_rst_err", 64'(err_count), 64'h0);
    @(negedge clk) reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_noval", 64'(memresp_val), 64'h0);
    end
    @(posedge clk);
    #1;
    send(mk_req(MEM_READ, 8'h0E, 32'h10, 2'd0, 32'h0), mk_resp(MEM_READ, 8'h0E, TEST_OK, 2'd0, 32'hDEADAAEF));
    drain();

    // LATENCY=0 instance: back-to-back, one accept every 2 cycles, saturation at 3
    reqs0[0] = mk_req(MEM_WRITE, 8'h21, 32'h0, 2'd0, 32'h11223344);
    exps0[0] = mk_resp(MEM_WRITE, 8'h21, TEST_OK, 2'd0, 32'h0);
    reqs0[1] = mk_req(MEM_READ, 8'h22, 32'h3, 2'd1, 32'h0);
    exps0[1] = mk_resp(MEM_READ, 8'h22, TEST_OK, 2'd1, 32'h00000011);
    reqs0[2] = mk_req(MEM_READ, 8'h23, 32'h1, 2'd3, 32'h0);
    exps0[2] = mk_resp(MEM_READ, 8'h23, TEST_OK, 2'd3, 32'h00112233);
    for (int i = 3; i < 7; i++) begin
      reqs0[i] = mk_req(MEM_READ, 8'(8'h24 + i), 32'h800, 2'd0, 32'h0);
      exps0[i] = mk_resp(MEM_READ, 8'(8'h24 + i), TEST_ERR, 2'd0, 32'h0);
    end
    for (int i = 0; i < 7; i++) begin
      expq0.push_back(exps0[i]);
      memreq_msg0 = reqs0[i];
      memreq_val0 = 1'b1;
      n = 0;
      @(negedge clk);
      while (!memreq_rdy0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!memreq_rdy0) chk("l0_send_timeout", 64'(n), 64'h0);
      @(posedge clk);
      #1 acc0[i] = cyc;
      chk("l0_val_next", 64'(memresp_val0), 64'h1);
      if (i > 0) chk("l0_spacing", 64'(acc0[i] - acc0[i-1]), 64'd2);
    end
    memreq_val0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("l0_drained", 64'(expq0.size()), 64'h0);
    chk("l0_err_sat", 64'(err_count0), 64'd3);
    chk("sb_empty", 64'(expq.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
